// File: rtl/gate_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweeper_pkg
// Shared definitions for the gate_sweeper stimulus-and-check stage:
//   - FSM state encoding (IDLE, RUN, DONE)
//   - reference truth tables for common two-input gates
//   - width of the per-vector settle counter
// -----------------------------------------------------------------------------
package gate_sweeper_pkg;

    // Width of the settle counter; SETTLE values 0..255 fit.
    localparam int unsigned SETTLE_W = 8;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Truth tables: bit v is the gate output for input vector v.
    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] NOR2_TT  = 4'b0001;
    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;

endpackage

// File: rtl/gate_sweeper_settle_timer.sv
// -----------------------------------------------------------------------------
// gate_sweeper_settle_timer
// Loadable down-counter that holds at zero, with a zero flag decoded from the
// count register.
// Ports:
//   clk      in  1  clock, rising edge
//   rst_n    in  1  asynchronous active-low reset (count -> 0)
//   load     in  1  load load_val on the next edge (has priority)
//   load_val in  W  value to load
//   zero     out 1  count register equals zero
// -----------------------------------------------------------------------------
module gate_sweeper_settle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count register: load, else decrement until zero, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/gate_sweeper.sv
// -----------------------------------------------------------------------------
// gate_sweeper
// Drives all 2^N input vectors into a combinational gate under test, waits
// SETTLE extra cycles per vector, samples the gate output s and compares it
// against the EXPECT truth table. Reports error count, first failing vector
// and a pass flag.
// Optional build macro:
//   GATE_SWEEPER_ABORT_EN  - when defined, the first mismatch ends the sweep.
// Ports:
//   clk      in  1    clock, rising edge
//   rst_n    in  1    asynchronous active-low reset
//   start    in  1    begin a sweep (only honoured in IDLE)
//   s        in  1    output of the gate under test
//   a        out N    registered input vector to the gate under test
//   busy     out 1    sweep in progress
//   done     out 1    one-cycle pulse at sweep end
//   pass     out 1    last completed sweep had no mismatches
//   err_cnt  out N+1  mismatches in current/last sweep
//   fail_vec out N    first mismatching vector (0 if none)
// -----------------------------------------------------------------------------
module gate_sweeper
    import gate_sweeper_pkg::*;
#(
    parameter int unsigned           N      = 2,
    parameter logic [(1<<N)-1:0]     EXPECT = 4'b0111,
    parameter int unsigned           SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         s,
    output logic [N-1:0] a,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] fail_vec
);

`ifdef GATE_SWEEPER_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    logic [1:0]   state_r;
    logic [1:0]   state_s;
    logic [N-1:0] a_s;
    logic         busy_s;
    logic         done_s;
    logic         pass_s;
    logic [N:0]   err_s;
    logic [N-1:0] fail_s;
    logic         load_s;
    logic         timer_zero_s;
    logic         mismatch_s;
    logic         last_s;
    logic [N:0]   err_inc_s;

    gate_sweeper_settle_timer #(
        .W        (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (SETTLE_V),
        .zero     (timer_zero_s)
    );

    assign mismatch_s = (s != EXPECT[a]);
    assign last_s     = (a == {N{1'b1}});
    // Error count including the sample taken at this edge.
    assign err_inc_s  = err_cnt + (N+1)'(mismatch_s);

    // Next-state and result-update logic for the sweep FSM.
    always_comb begin
        state_s = state_r;
        a_s     = a;
        busy_s  = busy;
        done_s  = 1'b0;
        pass_s  = pass;
        err_s   = err_cnt;
        fail_s  = fail_vec;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    busy_s  = 1'b1;
                    a_s     = '0;
                    err_s   = '0;
                    fail_s  = '0;
                    pass_s  = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (timer_zero_s) begin
                    err_s = err_inc_s;
                    // err_cnt still zero means this is the sweep's first mismatch.
                    if (mismatch_s && (err_cnt == '0)) begin
                        fail_s = a;
                    end else begin
                        fail_s = fail_vec;
                    end
                    if (last_s || (ABORT_EN && mismatch_s)) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_inc_s == '0);
                    end else begin
                        a_s    = a + N'(1);
                        load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            state_r  <= state_s;
            a        <= a_s;
            busy     <= busy_s;
            done     <= done_s;
            pass     <= pass_s;
            err_cnt  <= err_s;
            fail_vec <= fail_s;
        end
    end

endmodule

// File: tb/tb_gate_sweeper.sv
// -----------------------------------------------------------------------------
// tb_gate_sweeper
// Two sweepers: dut0 (EXPECT=NAND2, SETTLE=0) and dut1 (EXPECT=OR2, SETTLE=2).
// Each drives a behavioural gate whose truth table the bench chooses. The
// expected outputs at every cycle of a sweep are computed from the timing
// formulas: vector v is driven from edge k+v*(S+1) and sampled at edge
// k+(v+1)*(S+1); results come from the mismatch mask between the gate and
// the expected table.
// -----------------------------------------------------------------------------
module tb_gate_sweeper;
    import gate_sweeper_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic       s0, s1;
    logic [1:0] a0, a1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic [1:0] fail0, fail1;
    logic [3:0] g0_tt, g1_tt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    assign s0 = g0_tt[a0];
    assign s1 = g1_tt[a1];

    gate_sweeper #(.N(2), .EXPECT(NAND2_TT), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .s(s0), .a(a0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fail0)
    );

    gate_sweeper #(.N(2), .EXPECT(OR2_TT), .SETTLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s(s1), .a(a1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_set(input logic [3:0] v);
        int f;
        f = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) f = i;
        return f;
    endfunction

    task automatic chk_all(input int sel, input string ph, input int ea, input int eb,
                           input int ed, input int ep, input int ee, input int ef);
        chk($sformatf("d%0d %s a", sel, ph),        (sel != 0) ? 32'(a1)    : 32'(a0),    32'(ea));
        chk($sformatf("d%0d %s busy", sel, ph),     (sel != 0) ? 32'(busy1) : 32'(busy0), 32'(eb));
        chk($sformatf("d%0d %s done", sel, ph),     (sel != 0) ? 32'(done1) : 32'(done0), 32'(ed));
        chk($sformatf("d%0d %s pass", sel, ph),     (sel != 0) ? 32'(pass1) : 32'(pass0), 32'(ep));
        chk($sformatf("d%0d %s err_cnt", sel, ph),  (sel != 0) ? 32'(err1)  : 32'(err0),  32'(ee));
        chk($sformatf("d%0d %s fail_vec", sel, ph), (sel != 0) ? 32'(fail1) : 32'(fail0), 32'(ef));
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start1 = v;
        else          start0 = v;
    endtask

    // Call at a negedge with the selected DUT idle. mode: 0 pulse, 1 hold start
    // high throughout, 2 random start noise while busy. stop_at >= 0 returns
    // right after checking that cycle offset.
    task automatic run_sweep(input int sel, input int mode, input int stop_at);
        int          S, L, fin_err, fin_fail, endv, n, ea, eb, ed, ep, ee, ef;
        logic [3:0]  m, msk;
        S = (sel != 0) ? 2 : 0;
        m = (sel != 0) ? (g1_tt ^ OR2_TT) : (g0_tt ^ NAND2_TT);
`ifdef GATE_SWEEPER_ABORT_EN
        if (m != 4'd0) begin
            endv    = first_set(m);
            fin_err = 1;
        end else begin
            endv    = 3;
            fin_err = 0;
        end
`else
        endv    = 3;
        fin_err = popc(m);
`endif
        fin_fail = first_set(m);
        L = (endv + 1) * (S + 1);
        set_start(sel, 1'b1);
        @(posedge clk);
        for (int t = 0; t <= L + 1; t++) begin
            @(negedge clk);
            if (t < L) begin
                n   = t / (S + 1);
                msk = 4'((1 << n) - 1);
                ea = n; eb = 1; ed = 0; ep = 0;
                ee = popc(m & msk);
                ef = first_set(m & msk);
            end else begin
                ea = endv; eb = 0; ed = (t == L) ? 1 : 0;
                ee = fin_err; ef = fin_fail; ep = (fin_err == 0) ? 1 : 0;
            end
            chk_all(sel, $sformatf("t=%0d", t), ea, eb, ed, ep, ee, ef);
            if (t == stop_at) return;
            if (mode == 1)                set_start(sel, 1'b1);
            else if (mode == 2 && t <= L) set_start(sel, 1'($urandom_range(0, 1)));
            else                          set_start(sel, 1'b0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        g0_tt  = NAND2_TT;
        g1_tt  = OR2_TT;
        @(negedge clk);
        @(negedge clk);
        chk_all(0, "reset", 0, 0, 0, 0, 0, 0);
        chk_all(1, "reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NAND2 gate against NAND2 table: clean pass.
        run_sweep(0, 0, -1);
        // AND2 gate against NAND2 table: every vector mismatches.
        g0_tt = AND2_TT;
        run_sweep(0, 0, -1);
        // OR2 gate, SETTLE=2: each vector held three cycles.
        run_sweep(1, 0, -1);
        // NOR2 gate on the OR2 checker.
        g1_tt = NOR2_TT;
        run_sweep(1, 0, -1);

        // start held high: back-to-back sweeps, one per IDLE entry.
        g0_tt = NAND2_TT;
        run_sweep(0, 1, -1);
        run_sweep(0, 1, -1);
        start0 = 1'b0;
        @(negedge clk);
        chk_all(0, "after hold", 3, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of a sweep (a==2).
        run_sweep(0, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_all(0, "async rst", 0, 0, 0, 0, 0, 0);
        chk_all(1, "async rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0, 0, -1);

        // Output tied low against NAND2 table.
        g0_tt = 4'b0000;
        run_sweep(0, 0, -1);

        // Randomised gates, DUT choice, idle gaps and start noise.
        for (int r = 0; r < 16; r++) begin
            int sel;
            int gap;
            sel = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            if (sel != 0) g1_tt = 4'($urandom_range(0, 15));
            else          g0_tt = 4'($urandom_range(0, 15));
            for (int i = 0; i < gap; i++) @(negedge clk);
            run_sweep(sel, ($urandom_range(0, 1) != 0) ? 2 : 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
